// File: rtl/ahbl_sram_test_master.sv
// AHB-Lite pattern test initiator: writes seed+k to consecutive words or reads them
// back and counts mismatches, with pipelined address/data phases and ERROR abort.
`timescale 1ns/1ps
module ahbl_sram_test_master #(
   parameter int AHB_AWIDTH = 32,
   parameter int AHB_DWIDTH = 32,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   input  logic                  start,
   input  logic                  cmd_write,
   input  logic [AHB_AWIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [31:0]           cmd_seed,
   output logic                  busy,
   output logic                  done,
   output logic                  err_resp,
   output logic [15:0]           mismatch_cnt,
   output logic [AHB_AWIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [AHB_DWIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   input  logic [1:0]            HRESP,
   input  logic [AHB_DWIDTH-1:0] HRDATA
);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LAST,
      ST_ERR,
      ST_FIN
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            htrans_q;
   logic [AHB_AWIDTH-1:0] addr_q;
   logic                  hwrite_q;
   logic [AHB_DWIDTH-1:0] hwdata_q;
   logic [AHB_DWIDTH-1:0] pat_q;
   logic [AHB_DWIDTH-1:0] exp_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  beat_q;
   logic                  d_valid;
   logic                  err_q;
   logic [15:0]           mis_q;

   logic                  in_xfer;
   logic                  accept_cmd;
   logic                  err_first;
   logic                  addr_acc;
   logic                  data_done;
   logic                  last_beat;
   logic [AHB_AWIDTH-1:0] next_addr;
   logic                  unused_resp;

   assign unused_resp = HRESP[1];

   assign in_xfer    = (state_q == ST_ADDR) || (state_q == ST_LAST);
   assign accept_cmd = start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
   // First ERROR cycle: only meaningful while a data phase is outstanding.
   assign err_first  = in_xfer && d_valid && HRESP[0] && !HREADY;
   assign addr_acc   = (state_q == ST_ADDR) && HREADY;
   assign data_done  = in_xfer && d_valid && HREADY && !HRESP[0];
   assign last_beat  = (beat_q == (len_q - LEN_WIDTH'(1)));
   assign next_addr  = addr_q + AHB_AWIDTH'(4);

   assign HTRANS       = err_first ? HT_IDLE : htrans_q;
   assign HADDR        = addr_q;
   assign HWRITE       = hwrite_q;
   assign HWDATA       = hwdata_q;
   assign HSIZE        = 3'b010;
   assign HBURST       = 3'b001;
   assign err_resp     = err_q;
   assign mismatch_cnt = mis_q;

   // State register.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and status outputs; busy is low in FIN so it falls with done.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (cmd_len != '0) ? ST_ADDR : ST_FIN;
            end
         end
         ST_ADDR: begin
            busy = 1'b1;
            if (err_first) begin
               state_d = ST_ERR;
            end else if (HREADY && last_beat) begin
               state_d = ST_LAST;
            end
         end
         ST_LAST: begin
            busy = 1'b1;
            if (err_first) begin
               state_d = ST_ERR;
            end else if (HREADY) begin
               state_d = ST_FIN;
            end
         end
         ST_ERR: begin
            busy = 1'b1;
            if (HREADY) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done = 1'b1;
            if (start) begin
               state_d = (cmd_len != '0) ? ST_ADDR : ST_FIN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus pipeline and pattern tracking: pat_q is the pattern of the beat in the
   // address phase, exp_q the pattern of the beat in the data phase.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         htrans_q <= HT_IDLE;
         addr_q   <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         pat_q    <= '0;
         exp_q    <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         d_valid  <= 1'b0;
         err_q    <= 1'b0;
         mis_q    <= '0;
      end else begin
         if (accept_cmd) begin
            err_q <= 1'b0;
            mis_q <= '0;
            if (cmd_len != '0) begin
               htrans_q <= HT_NONSEQ;
               addr_q   <= cmd_addr & ~AHB_AWIDTH'(3);
               hwrite_q <= cmd_write;
               pat_q    <= cmd_seed;
               len_q    <= cmd_len;
               beat_q   <= '0;
               d_valid  <= 1'b0;
            end
         end
         if (addr_acc) begin
            d_valid <= 1'b1;
            exp_q   <= pat_q;
            pat_q   <= pat_q + AHB_DWIDTH'(1);
            if (hwrite_q) begin
               hwdata_q <= pat_q;
            end
            if (last_beat) begin
               htrans_q <= HT_IDLE;
            end else begin
               beat_q   <= beat_q + LEN_WIDTH'(1);
               addr_q   <= next_addr;
               htrans_q <= (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
            end
         end
         if (data_done && !hwrite_q && (HRDATA != exp_q) && (mis_q != 16'hFFFF)) begin
            mis_q <= mis_q + 16'd1;
         end
         if (err_first) begin
            htrans_q <= HT_IDLE;
         end
         if ((state_q == ST_LAST) && HREADY) begin
            d_valid <= 1'b0;
         end
         if ((state_q == ST_ERR) && HREADY) begin
            err_q   <= 1'b1;
            d_valid <= 1'b0;
         end
      end
   end

endmodule
